// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      KILL = 2'd3
   } fetch_state_e;

   // Redirect source indices; a lower index wins arbitration.
   localparam int REDIR_TRAP   = 0;
   localparam int REDIR_BRANCH = 1;
   localparam int REDIR_JUMP   = 2;

   localparam int DEFAULT_NUM_REDIR_SRC = 3;

endpackage

// File: rtl/redir_priority_arb.sv
// Fixed-priority redirect arbiter: one-hot grant to the lowest set request
// and a mux selecting that requester's target address.
module redir_priority_arb #(
   parameter int NUM_REDIR_SRC    = 3,
   parameter int INSTR_ADDR_WIDTH = 32
) (
   input  logic [NUM_REDIR_SRC-1:0]                  req,
   input  logic [NUM_REDIR_SRC*INSTR_ADDR_WIDTH-1:0] addr,
   output logic [NUM_REDIR_SRC-1:0]                  gnt,
   output logic [INSTR_ADDR_WIDTH-1:0]               target
);

   // Scan from the highest index down so the lowest set index is written last.
   always_comb begin
      gnt    = '0;
      target = '0;
      for (int i = NUM_REDIR_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            target = addr[i*INSTR_ADDR_WIDTH +: INSTR_ADDR_WIDTH];
         end
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC control, single-outstanding imem handshake,
// redirect arbitration with flush/kill. FETCH_STATS_EN adds fetch/kill counters.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int INSTR_ADDR_WIDTH = 32,
   parameter int INSTR_WIDTH      = 32,
   parameter int NUM_REDIR_SRC    = DEFAULT_NUM_REDIR_SRC
) (
   input  logic                                      clk,
   input  logic                                      sync_rst,
   input  logic                                      clk_en,
   input  logic                                      start,
   input  logic                                      halt_req,
   input  logic [INSTR_ADDR_WIDTH-1:0]               pc_addr,
   output logic                                      pc_stall,
   output logic                                      pc_load,
   output logic [INSTR_ADDR_WIDTH-1:0]               pc_load_addr,
   output logic                                      imem_req,
   output logic [INSTR_ADDR_WIDTH-1:0]               imem_addr,
   input  logic                                      imem_gnt,
   input  logic                                      imem_rvalid,
   input  logic [INSTR_WIDTH-1:0]                    imem_rdata,
   output logic                                      instr_valid,
   output logic [INSTR_WIDTH-1:0]                    instr_data,
   output logic [INSTR_ADDR_WIDTH-1:0]               instr_addr,
   input  logic                                      instr_ready,
   input  logic [NUM_REDIR_SRC-1:0]                  redir_req,
   input  logic [NUM_REDIR_SRC*INSTR_ADDR_WIDTH-1:0] redir_addr,
   output logic [NUM_REDIR_SRC-1:0]                  redir_ack,
   output logic                                      flush,
   output logic                                      busy
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]                               stat_fetch_cnt,
   output logic [31:0]                               stat_kill_cnt
`endif
);

   fetch_state_e state, state_next;

   logic                        active;
   logic                        any_redir;
   logic                        pop;
   logic                        buf_free;
   logic                        capture;
   logic                        discard;
   logic [NUM_REDIR_SRC-1:0]    grant;
   logic [INSTR_ADDR_WIDTH-1:0] target;
   logic [INSTR_ADDR_WIDTH-1:0] fetch_addr;
   logic                        buf_valid;
   logic [INSTR_WIDTH-1:0]      buf_data;
   logic [INSTR_ADDR_WIDTH-1:0] buf_addr;

   redir_priority_arb #(
      .NUM_REDIR_SRC    (NUM_REDIR_SRC),
      .INSTR_ADDR_WIDTH (INSTR_ADDR_WIDTH)
   ) u_arb (
      .req    (redir_req),
      .addr   (redir_addr),
      .gnt    (grant),
      .target (target)
   );

   assign active    = clk_en & ~sync_rst;
   assign any_redir = |redir_req;
   assign pop       = active & buf_valid & instr_ready;
   assign buf_free  = ~buf_valid | instr_ready;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (sync_rst) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (active) begin
         case (state)
            IDLE: if (start) state_next = REQ;
            REQ: begin
               if (halt_req)                 state_next = IDLE;
               else if (imem_req && imem_gnt) state_next = WAIT;
            end
            WAIT: begin
               if (imem_rvalid)    state_next = halt_req ? IDLE : REQ;
               else if (any_redir) state_next = KILL;
            end
            KILL: if (imem_rvalid) state_next = halt_req ? IDLE : REQ;
            default: state_next = IDLE;
         endcase
      end
   end

   // Every output falls back to its quiet value under reset or clk_en low.
   always_comb begin
      pc_stall     = 1'b1;
      pc_load      = 1'b0;
      pc_load_addr = '0;
      imem_req     = 1'b0;
      imem_addr    = '0;
      redir_ack    = '0;
      flush        = 1'b0;
      capture      = 1'b0;
      discard      = 1'b0;
      if (active) begin
         if (any_redir) begin
            pc_load      = 1'b1;
            pc_load_addr = target;
            redir_ack    = grant;
            flush        = 1'b1;
         end
         case (state)
            REQ: begin
               if (buf_free && !any_redir && !halt_req) begin
                  imem_req  = 1'b1;
                  imem_addr = pc_addr;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  if (any_redir) begin
                     discard = 1'b1;
                  end else begin
                     capture  = 1'b1;
                     pc_stall = 1'b0;
                  end
               end
            end
            KILL:    discard = imem_rvalid;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         buf_valid  <= 1'b0;
         buf_data   <= '0;
         buf_addr   <= '0;
         fetch_addr <= '0;
      end else if (clk_en) begin
         if (imem_req && imem_gnt) fetch_addr <= pc_addr;
         if (any_redir) begin
            buf_valid <= 1'b0;
         end else if (capture) begin
            buf_valid <= 1'b1;
            buf_data  <= imem_rdata;
            buf_addr  <= fetch_addr;
         end else if (pop) begin
            buf_valid <= 1'b0;
         end
      end
   end

   assign instr_valid = buf_valid;
   assign instr_data  = buf_data;
   assign instr_addr  = buf_addr;

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         stat_fetch_cnt <= '0;
         stat_kill_cnt  <= '0;
      end else begin
         if (capture) stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
         if (discard) stat_kill_cnt  <= stat_kill_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic against
// a flag-based behavioural model with a responding memory and a PC register.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          sync_rst, clk_en, start, halt_req;
   logic [AW-1:0] pc_addr;
   logic          pc_stall, pc_load;
   logic [AW-1:0] pc_load_addr;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt, imem_rvalid;
   logic [DW-1:0] imem_rdata;
   logic          instr_valid;
   logic [DW-1:0] instr_data;
   logic [AW-1:0] instr_addr;
   logic          instr_ready;
   logic [NR-1:0] redir_req, redir_ack;
   logic [NR*AW-1:0] redir_addr;
   logic          flush, busy;
`ifdef FETCH_STATS_EN
   logic [31:0]   stat_fetch_cnt, stat_kill_cnt;
`endif

   fetch_sequencer #(.INSTR_ADDR_WIDTH(AW), .INSTR_WIDTH(DW), .NUM_REDIR_SRC(NR)) dut (
      .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .start(start), .halt_req(halt_req),
      .pc_addr(pc_addr), .pc_stall(pc_stall), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
      .instr_ready(instr_ready), .redir_req(redir_req), .redir_addr(redir_addr),
      .redir_ack(redir_ack), .flush(flush), .busy(busy)
`ifdef FETCH_STATS_EN
      , .stat_fetch_cnt(stat_fetch_cnt), .stat_kill_cnt(stat_kill_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // Model: running = fetching enabled, outst = a granted fetch awaits its
   // response, doomed = that response must be thrown away.
   bit          m_running, m_outst, m_doomed, m_bv;
   logic [31:0] m_bdata, m_baddr, m_faddr, m_pc;
   logic [31:0] m_fcnt, m_kcnt;
   bit          mem_pend;
   int          mem_dly;
   int          mem_sel = 0;

   bit          e_act, e_any, e_req, e_cap, e_disc;
   int          e_win;
   logic [NR-1:0] e_ack;
   logic [AW-1:0] e_load_addr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      sync_rst = 0; clk_en = 1; start = 0; halt_req = 0; instr_ready = 1;
      imem_gnt = 0; redir_req = '0; redir_addr = '0;
   endtask

   task automatic drive_mem();
      pc_addr     = m_pc;
      imem_rvalid = clk_en && mem_pend && (mem_dly == 0);
      imem_rdata  = $urandom;
   endtask

   task automatic eval();
      #4;
      e_act = clk_en && !sync_rst;
      e_any = |redir_req;
      e_win = 0;
      while (e_win < NR && !redir_req[e_win]) e_win++;
      e_ack = '0;
      e_load_addr = '0;
      if (e_act && e_any) begin
         e_ack = NR'(1) << e_win;
         e_load_addr = redir_addr[e_win*AW +: AW];
      end
      e_req  = e_act && m_running && !m_outst && (!m_bv || instr_ready) && !e_any && !halt_req;
      e_cap  = e_act && m_outst && !m_doomed && imem_rvalid && !e_any;
      e_disc = e_act && m_outst && imem_rvalid && (m_doomed || e_any);
      if (chk_en) begin
         chk("pc_stall", pc_stall, !e_cap);
         chk("pc_load", pc_load, e_act && e_any);
         chk("pc_load_addr", pc_load_addr, e_load_addr);
         chk("redir_ack", redir_ack, e_ack);
         chk("flush", flush, e_act && e_any);
         chk("imem_req", imem_req, e_req);
         if (e_req) chk("imem_addr", imem_addr, m_pc);
         chk("busy", busy, m_running);
         chk("instr_valid", instr_valid, m_bv);
         if (m_bv) begin
            chk("instr_data", instr_data, m_bdata);
            chk("instr_addr", instr_addr, m_baddr);
         end
`ifdef FETCH_STATS_EN
         chk("stat_fetch_cnt", stat_fetch_cnt, m_fcnt);
         chk("stat_kill_cnt", stat_kill_cnt, m_kcnt);
`endif
      end
   endtask

   task automatic advance();
      bit acc;
      acc = e_req && imem_gnt;
      if (sync_rst) begin
         m_running = 0; m_outst = 0; m_doomed = 0; m_bv = 0;
         m_bdata = 0; m_baddr = 0; m_faddr = 0; m_fcnt = 0; m_kcnt = 0;
         mem_pend = 0; mem_dly = 0;
      end else if (clk_en) begin
         if (e_any)                    m_bv = 0;
         else if (e_cap) begin         m_bv = 1; m_bdata = imem_rdata; m_baddr = m_faddr; end
         else if (m_bv && instr_ready) m_bv = 0;
         if (e_cap)  m_fcnt = m_fcnt + 1;
         if (e_disc) m_kcnt = m_kcnt + 1;
         if (!m_running) begin
            if (start) m_running = 1;
         end else if (!m_outst) begin
            if (halt_req) m_running = 0;
            else if (acc) begin m_outst = 1; m_doomed = 0; m_faddr = m_pc; end
         end else if (imem_rvalid) begin
            m_outst = 0; m_doomed = 0; m_running = !halt_req;
         end else if (e_any) begin
            m_doomed = 1;
         end
         if (e_any)      m_pc = e_load_addr;
         else if (e_cap) m_pc = m_pc + 4;
         if (imem_rvalid)                 mem_pend = 0;
         else if (mem_pend && mem_dly > 0) mem_dly--;
         if (acc) begin
            mem_pend = 1;
            mem_dly  = (mem_sel >= 0) ? mem_sel : int'($urandom_range(0, 2));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      sync_rst = 1;
      m_pc = 0; mem_pend = 0; mem_dly = 0;
      @(posedge clk); #1;
      drive_mem(); eval(); advance();
      drive_mem(); eval(); advance();
      chk_en = 1;

      // Reset held, with a redirect request that must be ignored.
      redir_req = 3'b001; redir_addr = {64'h0, 32'h0000_0ABC};
      drive_mem(); eval();
      chk("rst pc_stall", pc_stall, 1); chk("rst pc_load", pc_load, 0);
      chk("rst pc_load_addr", pc_load_addr, 0); chk("rst imem_req", imem_req, 0);
      chk("rst imem_addr", imem_addr, 0); chk("rst instr_valid", instr_valid, 0);
      chk("rst instr_data", instr_data, 0); chk("rst instr_addr", instr_addr, 0);
      chk("rst redir_ack", redir_ack, 0); chk("rst flush", flush, 0); chk("rst busy", busy, 0);
      advance();

      // First fetch from 0x100, zero-wait memory.
      idle_inputs(); m_pc = 32'h100; start = 1;
      drive_mem(); eval(); chk("idle busy", busy, 0); advance();
      start = 0; imem_gnt = 1; mem_sel = 0;
      drive_mem(); eval(); chk("req1", imem_req, 1); chk("req1 addr", imem_addr, 32'h100); advance();
      imem_gnt = 0;
      drive_mem(); imem_rdata = 32'hDEAD_BEEF; eval(); chk("cap stall", pc_stall, 0); advance();

      // Buffer full, decode not ready.
      instr_ready = 0;
      drive_mem(); eval();
      chk("buf valid", instr_valid, 1); chk("buf data", instr_data, 32'hDEAD_BEEF);
      chk("buf addr", instr_addr, 32'h100); chk("full no req", imem_req, 0);
      chk("stall after", pc_stall, 1); advance();
      imem_gnt = 1;
      drive_mem(); eval(); chk("full no req2", imem_req, 0); advance();
      instr_ready = 1;
      drive_mem(); eval(); chk("drain req", imem_req, 1); chk("drain addr", imem_addr, 32'h104); advance();
      imem_gnt = 0;
      drive_mem(); imem_rdata = 32'h1234_5678; eval(); advance();

      // Redirect arbitration in REQ.
      redir_req = 3'b110; redir_addr = {32'h80, 32'h40, 32'hFFC}; imem_gnt = 1;
      drive_mem(); eval();
      chk("arb ack", redir_ack, 3'b010); chk("arb load", pc_load, 1);
      chk("arb addr", pc_load_addr, 32'h40); chk("arb flush", flush, 1); chk("arb no req", imem_req, 0);
      advance();
      redir_req = '0; mem_sel = 2;
      drive_mem(); eval();
      chk("flush pulse", flush, 0); chk("flushed buf", instr_valid, 0);
      chk("req after redir", imem_req, 1); chk("redir fetch", imem_addr, 32'h40); advance();

      // Redirect while waiting; late response is killed.
      imem_gnt = 0; redir_req = 3'b001; redir_addr = {64'h0, 32'h200};
      drive_mem(); eval(); chk("wait redir", pc_load_addr, 32'h200); advance();
      redir_req = '0;
      drive_mem(); eval(); chk("kill stall", pc_stall, 1); chk("kill no req", imem_req, 0);
      chk("kill busy", busy, 1); advance();
      drive_mem(); imem_rdata = 32'hBAD0_BAD0; eval(); chk("kill drop", pc_stall, 1); advance();
      imem_gnt = 1; mem_sel = 0;
      drive_mem(); eval();
      chk("kill empty", instr_valid, 0); chk("refetch", imem_req, 1); chk("refetch addr", imem_addr, 32'h200);
      advance();

      // Redirect coincident with the response.
      imem_gnt = 0; redir_req = 3'b100; redir_addr = {32'h300, 64'h0};
      drive_mem(); eval();
      chk("coinc flush", flush, 1); chk("coinc stall", pc_stall, 1); chk("coinc addr", pc_load_addr, 32'h300);
      advance();
      redir_req = '0;
      drive_mem(); eval();
      chk("coinc empty", instr_valid, 0); chk("coinc req", imem_req, 1); chk("coinc fetch", imem_addr, 32'h300);
      advance();

      // Halt before grant.
      halt_req = 1; imem_gnt = 1;
      drive_mem(); eval(); chk("halt no req", imem_req, 0); advance();
      halt_req = 0; imem_gnt = 0;
      drive_mem(); eval(); chk("halt idle", busy, 0); advance();

      // Reset in the middle of a wait.
      start = 1;
      drive_mem(); eval(); advance();
      start = 0; imem_gnt = 1; mem_sel = 2;
      drive_mem(); eval(); chk("pre-rst req", imem_req, 1); advance();
      imem_gnt = 0;
      drive_mem(); eval(); chk("pre-rst busy", busy, 1); advance();
      sync_rst = 1;
      drive_mem(); eval(); advance();
      sync_rst = 0;
      drive_mem(); eval();
      chk("post-rst busy", busy, 0); chk("post-rst stall", pc_stall, 1);
      chk("post-rst req", imem_req, 0); chk("post-rst valid", instr_valid, 0);
      advance();

      // Randomized traffic.
      mem_sel = -1;
      for (int c = 0; c < 5000; c++) begin
         sync_rst    = ($urandom_range(0, 299) == 0);
         clk_en      = ($urandom_range(0, 9) != 0);
         start       = ($urandom_range(0, 3) == 0);
         halt_req    = ($urandom_range(0, 19) == 0);
         instr_ready = ($urandom_range(0, 9) < 7);
         imem_gnt    = 1'($urandom_range(0, 1));
         redir_req   = ($urandom_range(0, 7) == 0) ? NR'($urandom_range(1, 7)) : '0;
         for (int s = 0; s < NR; s++) redir_addr[s*AW +: AW] = $urandom & 32'hFFFF_FFFC;
         drive_mem();
         eval();
         advance();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
